mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the cpu bus (address/datao/rw out, data in).
//  Holds program+data words, loads them from a host port after reset while
//  the cpu is held, then serves cpu reads (1-cycle registered) and writes.
//  Sits between the host loader and the cpu; only slave on the cpu bus.
// PARAMETERS
//  DEPTH   256  number of 64-bit words; word-addressed (cpu address = index)
//  DATA_W  64   word width; must match cpu bus width
//  AW      $clog2(DEPTH)  localparam, index width
// PORTS
//  clock     in   1       single clock; all state updates on posedge
//  reset     in   1       asynchronous, active-high
//  address   in   64      word index from cpu
//  datai     in   DATA_W  write data from cpu datao
//  rw        in   1       1 = read, 0 = write
//  data      out  DATA_W  read data to cpu data input, registered
//  ld_valid  in   1       host load word valid
//  ld_ready  out  1       responder accepts load word
//  ld_data   in   DATA_W  host load word
//  ld_last   in   1       marks final load word
//  cpu_hold  out  1       held high until load completes; drives cpu reset
//  fault     out  1       sticky: out-of-range access or load overflow
// BEHAVIOUR
//  Reset (async): state=LOAD, ld_ptr=0, data=0, ld_ready=1, cpu_hold=1,
//   fault=0. Memory contents not reset.
//  FSM LOAD: ld_ready=1. ld_valid&ld_ready -> mem[ld_ptr]<=ld_data,
//   ld_ptr+=1. Accepted word with ld_last -> RUN next edge.
//   ld_ptr==DEPTH-1 accepted without ld_last -> RUN, fault<=1.
//   cpu bus ignored in LOAD (no writes; data holds 0).
//  FSM RUN: ld_ready=0, cpu_hold=0 (deasserts the edge LOAD->RUN is taken).
//   rw=0, address<DEPTH: mem[address]<=datai at posedge.
//   rw=1, address<DEPTH: data<=mem[address] at posedge (latency 1).
//   address>=DEPTH (any of bits 63:AW set): write dropped, data<=0, fault<=1.
//   rw=0 cycle: data holds previous value.
//   Read of word written in previous cycle returns new value; single port,
//   so same-cycle read+write cannot occur.
//  RUN is terminal until reset; ld_valid in RUN is ignored (no back-pressure
//   deadlock: ld_ready low).
//  Reset mid-load: pointer restarts at 0; partially loaded words remain.
//  fault clears only on reset.
// STRUCTURE
//  Shared package: state enum {LOAD, RUN}, DATA_W constant (shared with cpu).
//  Sub-module mem_array: DEPTH x DATA_W, one sync write port, one sync read
//   port with registered output; responder muxes load vs cpu onto its write
//   port and range-checks before it.
// TESTING
//  Load 3 words (0x11,0x22,0x33, last on 3rd) -> ld_ready drops, cpu_hold
//   falls same edge; rw=1 addr 0,1,2 -> data 0x11,0x22,0x33 one edge later.
//  RUN: rw=0 addr 5 datai 0xDEAD, then rw=1 addr 5 -> data 0xDEAD next edge.
//  rw=1 address 0x100 (DEPTH=256) -> data 0, fault=1, stays 1 afterwards;
//   rw=0 addr 0x100 -> mem[0] unchanged.
//  Load DEPTH words, ld_last never set -> RUN after word DEPTH-1, fault=1.
//  Assert reset after 2 load words -> all outputs at reset values immediately
//   (async); reload from index 0 overwrites word 0.
//  ld_valid toggling with gaps -> only valid cycles advance ld_ptr.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder and the cpu it serves.
// Bus widths here must agree with the cpu side.
package mem_responder_pkg;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 64;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word storage with one synchronous write port and one synchronous read port
// whose registered output can also be cleared to zero.
module mem_responder_mem_array
   import mem_responder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic              rclr,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: storage has no reset so it maps onto RAM; only the output register is reset.
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)     rdata <= '0;
      else if (rclr) rdata <= '0;
      else if (re)   rdata <= mem[raddr];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side slave of the cpu bus: bulk-loaded from a host port while the
// cpu is held, then serves word-addressed cpu reads and writes.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] datai,
   input  logic              rw,
   output logic [DATA_W-1:0] data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              cpu_hold,
   output logic              fault
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_t            state, state_next;
   logic [AW-1:0]     ld_ptr;
   logic              ptr_inc;
   logic              fault_set;
   logic              in_range;
   logic              we, re, rclr;
   logic [AW-1:0]     waddr;
   logic [DATA_W-1:0] wdata;

   assign in_range = (address[ADDR_W-1:AW] == '0);

   // NOTE: every signal gets a default first so no path through this block infers a latch.
   always_comb begin
      state_next = state;
      ld_ready   = 1'b0;
      cpu_hold   = 1'b0;
      ptr_inc    = 1'b0;
      fault_set  = 1'b0;
      we         = 1'b0;
      re         = 1'b0;
      rclr       = 1'b0;
      waddr      = address[AW-1:0];
      wdata      = datai;
      if (state == LOAD) begin
         ld_ready = 1'b1;
         cpu_hold = 1'b1;
         if (ld_valid) begin
            we      = 1'b1;
            waddr   = ld_ptr;
            wdata   = ld_data;
            ptr_inc = 1'b1;
            if (ld_last) begin
               state_next = RUN;
            end else if (ld_ptr == LAST_IDX) begin
               // memory full without an end marker: stop loading and flag it
               state_next = RUN;
               fault_set  = 1'b1;
            end
         end
      end else begin
         if (!in_range) begin
            rclr      = 1'b1;
            fault_set = 1'b1;
         end else if (rw) begin
            re = 1'b1;
         end else begin
            we = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= LOAD;
         ld_ptr <= '0;
         fault  <= 1'b0;
      end else begin
         state <= state_next;
         if (ptr_inc)   ld_ptr <= ld_ptr + AW'(1);
         if (fault_set) fault  <= 1'b1;
      end
   end

   mem_responder_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clock (clock),
      .reset (reset),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .re    (re),
      .rclr  (rclr),
      .raddr (address[AW-1:0]),
      .rdata (data)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a behavioural memory model predicts the
// outputs after every clocked cycle and a monitor compares them.
module tb_mem_responder;

   localparam int DEPTH = 256;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] address = '0;
   logic [63:0] datai = '0;
   logic        rw = 1'b1;
   logic [63:0] data;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [63:0] ld_data = '0;
   logic        ld_last = 1'b0;
   logic        cpu_hold;
   logic        fault;

   mem_responder #(.DEPTH(DEPTH)) dut (
      .clock    (clock),
      .reset    (reset),
      .address  (address),
      .datai    (datai),
      .rw       (rw),
      .data     (data),
      .ld_valid (ld_valid),
      .ld_ready (ld_ready),
      .ld_data  (ld_data),
      .ld_last  (ld_last),
      .cpu_hold (cpu_hold),
      .fault    (fault)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [63:0] data;
      bit          fault;
      bit          run;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model
   logic [63:0] mem_m [DEPTH];
   bit          written [DEPTH];
   int          ptr_m = 0;
   bit          run_m = 0;
   bit          fault_m = 0;
   logic [63:0] data_m = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // one clocked cycle: drive at negedge, advance the model, queue the prediction
   task automatic cycle(input bit lv, input logic [63:0] ld, input bit ll,
                        input bit r, input logic [63:0] a, input logic [63:0] di);
      exp_t e;
      @(negedge clock);
      ld_valid = lv;
      ld_data  = ld;
      ld_last  = ll;
      rw       = r;
      address  = a;
      datai    = di;
      if (!run_m) begin
         if (lv) begin
            mem_m[ptr_m]   = ld;
            written[ptr_m] = 1'b1;
            ptr_m++;
            if (ll) begin
               run_m = 1'b1;
            end else if (ptr_m == DEPTH) begin
               run_m   = 1'b1;
               fault_m = 1'b1;
            end
         end
      end else if (a >= 64'(DEPTH)) begin
         fault_m = 1'b1;
         data_m  = '0;
      end else if (r) begin
         data_m = mem_m[a];
      end else begin
         mem_m[a]   = di;
         written[a] = 1'b1;
      end
      e.data  = data_m;
      e.fault = fault_m;
      e.run   = run_m;
      exp_q.push_back(e);
      @(posedge clock);
   endtask

   always begin
      exp_t e;
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("data", data, e.data);
         check("fault", 64'(fault), 64'(e.fault));
         check("ld_ready", 64'(ld_ready), 64'(!e.run));
         check("cpu_hold", 64'(cpu_hold), 64'(!e.run));
      end
   end

   function automatic logic [63:0] rand_addr(input int span);
      logic [63:0] a;
      if ($urandom_range(0, 7) == 0) begin
         a = {$urandom, $urandom} | (64'(1) << $urandom_range(8, 63));
      end else begin
         a = 64'($urandom_range(0, span - 1));
      end
      return a;
   endfunction

   task automatic cpu_random(input int n, input int span);
      for (int i = 0; i < n; i++) begin
         logic [63:0] a;
         bit          r;
         a = rand_addr(span);
         r = 1'($urandom_range(0, 1));
         if (r && a < 64'(DEPTH) && !written[a]) r = 1'b0;
         cycle(1'b0, '0, 1'b0, r, a, {$urandom, $urandom});
      end
   endtask

   // load one word after 0..2 idle cycles; the cpu bus carries noise throughout
   task automatic load_word(input logic [63:0] w, input bit last);
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++)
         cycle(1'b0, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), rand_addr(DEPTH), {$urandom, $urandom});
      cycle(1'b1, w, last, 1'($urandom_range(0, 1)), rand_addr(DEPTH), {$urandom, $urandom});
   endtask

   task automatic async_reset();
      @(negedge clock);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("rst data", data, 64'h0);
      check("rst fault", 64'(fault), 64'h0);
      check("rst ld_ready", 64'(ld_ready), 64'h1);
      check("rst cpu_hold", 64'(cpu_hold), 64'h1);
      ptr_m   = 0;
      run_m   = 1'b0;
      fault_m = 1'b0;
      data_m  = '0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;
      #1;
      check("por data", data, 64'h0);
      check("por fault", 64'(fault), 64'h0);
      check("por ld_ready", 64'(ld_ready), 64'h1);
      check("por cpu_hold", 64'(cpu_hold), 64'h1);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // short load with gaps, then directed cpu traffic
      load_word(64'h11, 1'b0);
      load_word(64'h22, 1'b0);
      load_word(64'h33, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b1, 64'd0, '0);
      cycle(1'b0, '0, 1'b0, 1'b1, 64'd1, '0);
      cycle(1'b0, '0, 1'b0, 1'b1, 64'd2, '0);
      cycle(1'b0, '0, 1'b0, 1'b0, 64'd5, 64'hDEAD);
      cycle(1'b0, '0, 1'b0, 1'b1, 64'd5, '0);
      cycle(1'b0, '0, 1'b0, 1'b0, 64'd6, 64'h1234);
      cycle(1'b0, 64'h77, 1'b1, 1'b0, 64'd7, 64'h5678);
      cycle(1'b1, 64'h99, 1'b1, 1'b1, 64'd6, '0);
      cycle(1'b0, '0, 1'b0, 1'b1, 64'h100, '0);
      cycle(1'b0, '0, 1'b0, 1'b1, 64'd2, '0);
      cycle(1'b0, '0, 1'b0, 1'b0, 64'h100, 64'hFFFF);
      cycle(1'b0, '0, 1'b0, 1'b1, 64'd0, '0);
      cycle(1'b0, '0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, '0);
      cpu_random(60, 16);
      cycle(1'b0, '0, 1'b0, 1'b1, 64'd1, '0);

      // async reset out of RUN, then interrupted reload
      async_reset();
      load_word(64'hA0, 1'b0);
      load_word(64'hA1, 1'b0);
      async_reset();
      load_word(64'hB0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b1, 64'd0, '0);
      cycle(1'b0, '0, 1'b0, 1'b1, 64'd1, '0);
      cycle(1'b0, '0, 1'b0, 1'b1, 64'd2, '0);
      cpu_random(20, 16);

      // full-depth load without an end marker
      async_reset();
      for (int i = 0; i < DEPTH; i++) load_word({$urandom, $urandom}, 1'b0);
      cycle(1'b1, 64'hCAFE, 1'b1, 1'b1, 64'd3, '0);
      cpu_random(120, DEPTH);

      @(negedge clock);
      check("queue drained", 64'(exp_q.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
